// File: rtl/branch_resolver_pkg.sv
// Shared constants and entry layout helpers for the branch resolver.
// A queue entry is packed as {index, pred, pc, target}, with target in the low bits.
package branch_resolver_pkg;

  localparam int          PC_STEP = 4;
  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;
  localparam int          TGT_OFF = 0;

  function automatic int pc_off(input int addr_w);
    return addr_w;
  endfunction

  function automatic int pred_off(input int addr_w);
    return 2 * addr_w;
  endfunction

  function automatic int idx_off(input int addr_w);
    return 2 * addr_w + 1;
  endfunction

  function automatic int entry_w(input int addr_w, input int idx_w);
    return 2 * addr_w + 1 + idx_w;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == SAT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_queue.sv
// In-order storage for in-flight branch predictions: circular buffer with
// push/pop/flush and a combinational head read.
module branch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count_q;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop frees the head slot this cycle, so a simultaneous push fits even when full.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolver.sv
// Checks queued decode-stage branch predictions against the MEM-stage outcome,
// producing registered redirect and BHT-update commands plus accuracy counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [IDX_W-1:0]  push_index,
  input  logic              push_pred,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [ADDR_W-1:0] push_target,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              upd_valid,
  output logic [IDX_W-1:0]  upd_index,
  output logic              upd_taken,
  output logic [31:0]       total_cnt,
  output logic [31:0]       mispred_cnt,
  output logic              underflow_err
);

  localparam int             ENTRY_W = entry_w(ADDR_W, IDX_W);
  localparam int             PC_OFF  = pc_off(ADDR_W);
  localparam int             PRED_OFF = pred_off(ADDR_W);
  localparam int             IDX_OFF = idx_off(ADDR_W);
  localparam int             CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic [CNT_W-1:0]   q_count;
  logic               q_empty;

  logic [ADDR_W-1:0]  head_target;
  logic [ADDR_W-1:0]  head_pc;
  logic               head_pred;
  logic [IDX_W-1:0]   head_index;

  logic               pop_do;
  logic               mis_do;
  logic [ADDR_W-1:0]  redirect_next;

  logic               mispredict_q;
  logic [ADDR_W-1:0]  redirect_q;
  logic               upd_valid_q;
  logic [IDX_W-1:0]   upd_index_q;
  logic               upd_taken_q;
  logic [31:0]        total_q;
  logic [31:0]        mispred_q;
  logic               underflow_q;

  assign push_data = {push_index, push_pred, push_pc, push_target};

  assign head_target = head_data[TGT_OFF +: ADDR_W];
  assign head_pc     = head_data[PC_OFF +: ADDR_W];
  assign head_pred   = head_data[PRED_OFF];
  assign head_index  = head_data[IDX_OFF +: IDX_W];

  assign push_ready = (q_count != DEPTH_C);

  // A mispredict flushes every younger (wrong-path) entry, including any push this cycle.
  assign pop_do        = resolve_valid & ~q_empty;
  assign mis_do        = pop_do & (head_pred != resolve_taken);
  assign redirect_next = resolve_taken ? head_target : head_pc + ADDR_W'(PC_STEP);

  branch_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (pop_do),
    .flush     (mis_do),
    .head_data (head_data),
    .count     (q_count),
    .empty     (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      upd_valid_q  <= 1'b0;
      upd_index_q  <= '0;
      upd_taken_q  <= 1'b0;
      total_q      <= '0;
      mispred_q    <= '0;
      underflow_q  <= 1'b0;
    end else begin
      mispredict_q <= mis_do;
      upd_valid_q  <= pop_do;
      if (pop_do) begin
        redirect_q  <= redirect_next;
        upd_index_q <= head_index;
        upd_taken_q <= resolve_taken;
        total_q     <= sat_inc(total_q);
      end
      if (mis_do) mispred_q <= sat_inc(mispred_q);
      if (resolve_valid && q_empty) underflow_q <= 1'b1;
    end
  end

  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_q;
  assign upd_valid     = upd_valid_q;
  assign upd_index     = upd_index_q;
  assign upd_taken     = upd_taken_q;
  assign total_cnt     = total_q;
  assign mispred_cnt   = mispred_q;
  assign underflow_err = underflow_q;

endmodule
